// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of the async FIFO among
// num_req requesters. It grants round-robin in bursts of up to max_burst words,
// stalls on full and keeps a wrapping count of the writes it has issued.
module fifo_wr_arbiter #(
    parameter int data_width = 8,
    parameter int num_req    = 4,
    parameter int max_burst  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req*data_width-1:0] req_data,
    input  logic [num_req-1:0]            req_last,
    output logic [num_req-1:0]            req_ready,
    input  logic                          full,
    output logic [data_width-1:0]         data_in,
    output logic                          wr_en,
    output logic [num_req-1:0]            grant,
    output logic                          busy,
    output logic [15:0]                   words_written
);

    localparam int IdxW = (num_req > 1) ? $clog2(num_req) : 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_e;

    state_e                 state_q, state_d;
    logic [num_req-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]        last_idx_q, last_idx_d;
    logic [3:0]             burst_cnt_q, burst_cnt_d;
    logic [15:0]            words_q, words_d;

    logic                   owner_valid;
    logic                   owner_last;
    logic                   write_fire;
    logic [data_width-1:0]  owner_data;
    logic                   found;
    logic [IdxW-1:0]        cand;

    // View of the current owner's request lines, selected by the one-hot grant
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        owner_last  = |(req_last & grant_q);
        owner_data  = '0;
        for (int i = 0; i < num_req; i++) begin
            if (grant_q[i]) begin
                owner_data = owner_data | req_data[i*data_width +: data_width];
            end
        end
        write_fire = (state_q == XFER) && owner_valid && !full;
    end

    // State register; reset leaves the last owner at num_req-1 so requester 0 wins first
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_idx_q  <= IdxW'(num_req - 1);
            burst_cnt_q <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_idx_q  <= last_idx_d;
            burst_cnt_q <= burst_cnt_d;
            words_q     <= words_d;
        end
    end

    // Next state: round-robin pick in IDLE, burst accounting and release in XFER
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_idx_d  = last_idx_q;
        burst_cnt_d = burst_cnt_q;
        words_d     = words_q;
        found       = 1'b0;
        cand        = '0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= num_req; k++) begin
                    cand = IdxW'((int'(last_idx_q) + k) % num_req);
                    if (!found && req_valid[cand]) begin
                        found       = 1'b1;
                        grant_d     = '0;
                        grant_d[cand] = 1'b1;
                        last_idx_d  = cand;
                    end
                end
                if (found) begin
                    state_d     = XFER;
                    burst_cnt_d = '0;
                end
            end
            XFER: begin
                if (write_fire) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    words_d     = words_q + 16'd1;
                    if (owner_last || (burst_cnt_d == 4'(max_burst))) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (!owner_valid) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: combinational from registered owner and live request/full inputs
    always_comb begin
        busy          = (state_q == XFER);
        wr_en         = write_fire;
        data_in       = write_fire ? owner_data : '0;
        req_ready     = ((state_q == XFER) && !full) ? grant_q : '0;
        grant         = grant_q;
        words_written = words_q;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed tests with a scoreboard of expected FIFO writes.
// A second instance with max_burst=15 runs the long counter-wrap test in parallel.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } expItem_t;

    // Main instance signals
    logic              wr_clk;
    logic              wr_rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              full;
    logic [DW-1:0]     data_in;
    logic              wr_en;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [15:0]       words_written;

    // Wrap-test instance signals
    logic              rstB;
    logic [NR-1:0]     validB;
    logic [NR*DW-1:0]  dataB;
    logic [NR-1:0]     lastB;
    logic [NR-1:0]     readyB;
    logic              fullB;
    logic [DW-1:0]     dataInB;
    logic              wrEnB;
    logic [NR-1:0]     grantB;
    logic              busyB;
    logic [15:0]       wordsB;

    expItem_t          sbQ[$];
    logic [8:0]        wordQ[NR][$];
    int                writeEdge[$];
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;
    int                expWords = 0;
    logic [NR-1:0]     accMask;
    bit                bDone = 0;

    fifo_wr_arbiter #(.data_width(DW), .num_req(NR), .max_burst(4)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .full(full), .data_in(data_in),
        .wr_en(wr_en), .grant(grant), .busy(busy), .words_written(words_written)
    );

    fifo_wr_arbiter #(.data_width(DW), .num_req(NR), .max_burst(15)) dutB (
        .wr_clk(wr_clk), .wr_rst(rstB), .req_valid(validB), .req_data(dataB),
        .req_last(lastB), .req_ready(readyB), .full(fullB), .data_in(dataInB),
        .wr_en(wrEnB), .grant(grantB), .busy(busyB), .words_written(wordsB)
    );

    // Free-running 10 ns write clock
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Edge counter used to time writes relative to stimulus
    initial begin
        forever begin
            @(posedge wr_clk);
            cyc++;
        end
    end

    // Compare one value against the bench's expectation and count the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue one word (with its last flag) on a requester's stimulus queue
    task automatic applyStimulus(input int idx, input logic [7:0] d, input logic l);
        wordQ[idx].push_back({l, d});
    endtask

    // Push a hand-computed expected FIFO write into the scoreboard
    task automatic expectWrite(input logic [1:0] o, input logic [7:0] d);
        expItem_t e;
        e.owner = o;
        e.data  = d;
        sbQ.push_back(e);
    endtask

    // Present the head of each requester queue on the request lines
    task automatic driveReqs();
        logic [8:0] w;
        for (int i = 0; i < NR; i++) begin
            if (wordQ[i].size() > 0) begin
                w = wordQ[i][0];
                req_valid[i]            = 1'b1;
                req_data[i*DW +: DW]    = w[7:0];
                req_last[i]             = w[8];
            end else begin
                req_valid[i]            = 1'b0;
                req_data[i*DW +: DW]    = '0;
                req_last[i]             = 1'b0;
            end
        end
    endtask

    task automatic flushQueues();
        for (int i = 0; i < NR; i++) wordQ[i].delete();
    endtask

    task automatic waitEdges(input int n);
        repeat (n) begin
            @(posedge wr_clk);
            #1;
        end
    endtask

    function automatic logic [1:0] ownerOf(input logic [NR-1:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    function automatic int edgeAt(input int i);
        if (i < writeEdge.size()) return writeEdge[i];
        return -1000;
    endfunction

    // Wait (bounded) for every expected write to be seen, then clear leftovers
    task automatic waitDrain(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (sbQ.size() > 0 && n < maxCycles) begin
            @(posedge wr_clk);
            #1;
            n++;
        end
        checkOutput({tag, "_drain"}, sbQ.size(), 0);
        sbQ.delete();
    endtask

    // Hold reset for two edges with all requests and full cleared
    task automatic doReset();
        wr_rst = 1'b1;
        full   = 1'b0;
        flushQueues();
        driveReqs();
        waitEdges(2);
        wr_rst = 1'b0;
    endtask

    // Requester model: a word leaves its queue once it was accepted on the edge
    initial begin
        forever begin
            @(negedge wr_clk);
            accMask = req_ready & req_valid;
            @(posedge wr_clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (accMask[i] && wordQ[i].size() > 0) void'(wordQ[i].pop_front());
            end
            driveReqs();
        end
    end

    // Scoreboard monitor: every FIFO write must match the next expected word and owner
    initial begin
        expItem_t e;
        forever begin
            @(negedge wr_clk);
            if (wr_rst) begin
                expWords = 0;
            end else if (wr_en) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_unexpected_write: got data 0x%0h owner %0d, no write expected",
                             data_in, ownerOf(grant));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_data", data_in, e.data);
                    checkOutput("sb_owner", ownerOf(grant), e.owner);
                end
                checkOutput("sb_words_written", words_written, expWords[15:0]);
                expWords++;
                writeEdge.push_back(cyc + 1);
            end
        end
    end

    // Counter wrap: 65535 writes through the max_burst=15 instance, then two more
    initial begin : wrapTest
        int accB;
        int guard;
        int n;
        rstB   = 1'b0;
        validB = '0;
        dataB  = '0;
        lastB  = '0;
        fullB  = 1'b0;
        #1 rstB = 1'b1;
        repeat (2) @(posedge wr_clk);
        #2 rstB = 1'b0;
        accB   = 0;
        guard  = 0;
        validB = 4'b0001;
        while (accB < 65535 && guard < 80000) begin
            @(negedge wr_clk);
            if (wrEnB) begin
                checkOutput("wrap_data", dataInB, accB[7:0]);
                checkOutput("wrap_count", wordsB, accB[15:0]);
                accB++;
            end
            @(posedge wr_clk);
            #2;
            guard++;
            dataB[7:0] = accB[7:0];
            if (accB == 65535) validB = '0;
        end
        checkOutput("wrap_preload_writes", accB, 65535);
        @(negedge wr_clk);
        checkOutput("wrap_ffff", wordsB, 16'hFFFF);
        checkOutput("wrap_idle_busy", busyB, 1'b0);
        @(posedge wr_clk);
        #2;
        validB     = 4'b0001;
        dataB[7:0] = 8'h5A;
        n = 0;
        do begin
            @(negedge wr_clk);
            n++;
        end while (!wrEnB && n < 10);
        checkOutput("wrap_extra1_data", dataInB, 8'h5A);
        @(posedge wr_clk);
        #2;
        dataB[7:0] = 8'hA5;
        @(negedge wr_clk);
        checkOutput("wrap_rollover", wordsB, 16'h0000);
        checkOutput("wrap_extra2_data", dataInB, 8'hA5);
        checkOutput("wrap_rollover_grant", grantB, 4'b0001);
        @(posedge wr_clk);
        #2;
        validB = '0;
        @(negedge wr_clk);
        checkOutput("wrap_after", wordsB, 16'h0001);
        checkOutput("wrap_after_wr_en", wrEnB, 1'b0);
        bDone = 1'b1;
    end

    // Directed tests on the max_burst=4 instance
    initial begin : mainTest
        int base;
        int v;
        int g;
        wr_rst    = 1'b0;
        full      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        #1 wr_rst = 1'b1;
        #2;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_en", wr_en, 1'b0);
        checkOutput("rst_data_in", data_in, 8'h00);
        checkOutput("rst_req_ready", req_ready, 4'b0000);
        checkOutput("rst_grant", grant, 4'b0000);
        checkOutput("rst_words", words_written, 16'h0000);

        // Single requester, three words ending with last
        doReset();
        base = writeEdge.size();
        applyStimulus(0, 8'hA1, 1'b0);
        applyStimulus(0, 8'hA2, 1'b0);
        applyStimulus(0, 8'hA3, 1'b1);
        v = cyc;
        expectWrite(2'd0, 8'hA1);
        expectWrite(2'd0, 8'hA2);
        expectWrite(2'd0, 8'hA3);
        waitDrain("t1", 20);
        checkOutput("t1_latency", edgeAt(base) - v, 2);
        checkOutput("t1_consec_a", edgeAt(base + 1) - edgeAt(base), 1);
        checkOutput("t1_consec_b", edgeAt(base + 2) - edgeAt(base + 1), 1);
        @(negedge wr_clk);
        checkOutput("t1_idle_busy", busy, 1'b0);
        checkOutput("t1_words", words_written, 16'd3);

        // All requesters valid, bursts of four, no last
        doReset();
        base = writeEdge.size();
        for (int j = 0; j < 8; j++) applyStimulus(0, 8'(j), 1'b0);
        for (int i = 1; i < NR; i++) begin
            for (int j = 0; j < 4; j++) applyStimulus(i, 8'(i * 16 + j), 1'b0);
        end
        for (int j = 0; j < 4; j++) expectWrite(2'd0, 8'(j));
        for (int i = 1; i < NR; i++) begin
            for (int j = 0; j < 4; j++) expectWrite(2'(i), 8'(i * 16 + j));
        end
        for (int j = 4; j < 8; j++) expectWrite(2'd0, 8'(j));
        waitDrain("t2", 60);
        checkOutput("t2_writes", writeEdge.size() - base, 20);
        checkOutput("t2_span", edgeAt(base + 19) - edgeAt(base) + 1, 24);
        checkOutput("t2_bubble", edgeAt(base + 4) - edgeAt(base + 3), 2);
        @(negedge wr_clk);
        checkOutput("t2_idle_busy", busy, 1'b0);

        // full held for five cycles while word 2 of 4 is waiting
        doReset();
        base = writeEdge.size();
        for (int j = 0; j < 4; j++) applyStimulus(0, 8'(8'hC0 + j), 1'b0);
        for (int j = 0; j < 4; j++) expectWrite(2'd0, 8'(8'hC0 + j));
        waitEdges(2);
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge wr_clk);
            checkOutput("t3_stall_wr_en", wr_en, 1'b0);
            checkOutput("t3_stall_ready", req_ready, 4'b0000);
            checkOutput("t3_stall_words", words_written, 16'd1);
            waitEdges(1);
        end
        full = 1'b0;
        waitDrain("t3", 20);
        checkOutput("t3_resume_gap", edgeAt(base + 1) - edgeAt(base), 6);
        checkOutput("t3_tail", edgeAt(base + 3) - edgeAt(base + 1), 2);
        @(negedge wr_clk);
        checkOutput("t3_idle_busy", busy, 1'b0);
        checkOutput("t3_words", words_written, 16'd4);

        // Owner drops valid after one word while requester 2 waits
        doReset();
        base = writeEdge.size();
        applyStimulus(0, 8'h40, 1'b0);
        applyStimulus(2, 8'h42, 1'b0);
        applyStimulus(2, 8'h43, 1'b1);
        expectWrite(2'd0, 8'h40);
        expectWrite(2'd2, 8'h42);
        expectWrite(2'd2, 8'h43);
        waitEdges(3);
        @(negedge wr_clk);
        checkOutput("t4_released_grant", grant, 4'b0000);
        checkOutput("t4_released_busy", busy, 1'b0);
        waitEdges(1);
        @(negedge wr_clk);
        checkOutput("t4_regrant", grant, 4'b0100);
        waitDrain("t4", 20);
        checkOutput("t4_handover", edgeAt(base + 1) - edgeAt(base), 3);
        @(negedge wr_clk);
        checkOutput("t4_words", words_written, 16'd3);

        // Asynchronous reset while word 2 of a burst is on the port
        doReset();
        for (int j = 0; j < 4; j++) applyStimulus(0, 8'(8'h60 + j), 1'b0);
        expectWrite(2'd0, 8'h60);
        waitEdges(2);
        #2;
        checkOutput("t5_pre_wr_en", wr_en, 1'b1);
        checkOutput("t5_pre_data", data_in, 8'h61);
        wr_rst = 1'b1;
        flushQueues();
        driveReqs();
        #1;
        checkOutput("t5_rst_wr_en", wr_en, 1'b0);
        checkOutput("t5_rst_grant", grant, 4'b0000);
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_words", words_written, 16'd0);
        waitEdges(2);
        wr_rst = 1'b0;
        waitDrain("t5a", 5);
        base = writeEdge.size();
        applyStimulus(0, 8'h70, 1'b1);
        applyStimulus(1, 8'h71, 1'b1);
        v = cyc;
        expectWrite(2'd0, 8'h70);
        expectWrite(2'd1, 8'h71);
        waitDrain("t5b", 20);
        checkOutput("t5_first_latency", edgeAt(base) - v, 2);

        // Wait (bounded) for the wrap test on the second instance
        g = 0;
        while (!bDone && g < 90000) begin
            @(posedge wr_clk);
            g++;
        end
        checkOutput("wrap_done", bDone, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the async FIFO (8-bit data, 16 entries) among `num_req` requesters. It runs entirely in the FIFO write clock domain, grants requesters round-robin in bursts, and drives `data_in`/`wr_en` while honouring `full`. A running count of written words supports scoreboard cross-checks.

## Interface
- `data_width`, default 8: word width; equals the FIFO `data_width`.
- `num_req`, default 4: number of requesters, 2..8.
- `max_burst`, default 4: maximum words per grant, 1..15.

- `wr_clk`  in  1: write-domain clock; all state on rising edge.
- `wr_rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  num_req: requester i has a word on its slice of `req_data`.
- `req_data`  in  num_req*data_width: requester i data at bits [i*data_width +: data_width].
- `req_last`  in  num_req: current word of requester i ends its burst.
- `req_ready`  out  num_req: word of granted requester accepted this cycle.
- `full`  in  1: FIFO full flag.
- `data_in`  out  data_width: to FIFO `data_in`.
- `wr_en`  out  1: to FIFO `wr_en`.
- `grant`  out  num_req: one-hot current owner; all-zero in IDLE.
- `busy`  out  1: high in XFER.
- `words_written`  out  16: count of FIFO writes issued, wraps at 16'hFFFF -> 0.

## Operation
- States: IDLE, XFER. Registers: `state`, `grant`, `last_idx`, `burst_cnt` (4 bits), `words_written`.
- IDLE: if any `req_valid`, select the first asserted index scanning `last_idx+1, last_idx+2, ...` modulo `num_req`. Load the one-hot `grant`, set `last_idx` to the selected index, clear `burst_cnt`, and go to XFER. With no request, stay in IDLE.
- XFER, owner g:
  - `req_ready[g] = !full`. All other `req_ready` bits are 0.
  - `wr_en = req_valid[g] && !full`.
  - `data_in` = slice g of `req_data` when `wr_en` is high, else 0.
  - These outputs are combinational from the registered `grant`/`state` and the live inputs.
- On a write edge, `burst_cnt` and `words_written` increment by 1.
- XFER -> IDLE on the first of:
  - a write with `req_last[g]` high;
  - a write that makes `burst_cnt == max_burst`;
  - `req_valid[g]` low, which releases the grant without a write.
- `full` high in XFER: no write, stay in XFER, counters hold. There is no timeout.
- `req_valid`/`req_last` of non-granted requesters are ignored.

## Timing
- Reset values, asserted asynchronously:
  - `state`=IDLE, `grant`=0, `last_idx`=num_req-1 (so requester 0 has first priority), `burst_cnt`=0, `words_written`=0.
  - `busy`=0, `wr_en`=0, `data_in`=0, `req_ready`=0.
- Reset mid-burst aborts the burst immediately. No write occurs on any edge where `wr_rst` is high.
- Latency: `req_valid` high before edge k means grant at edge k and first FIFO write at edge k+1.
- Within a burst, one word is written per unstalled cycle.
- Exactly one IDLE bubble cycle separates consecutive grants. Peak throughput is max_burst/(max_burst+1).
- `full` rising at edge k blocks the write in cycle k with zero latency. Writing resumes in the first cycle in which `full` is low.
- `req_last` on the write that also reaches `max_burst` produces a single exit; no double count.
- `words_written` wraps 0xFFFF -> 0x0000 without affecting any other output.

## Test plan
- Single requester: req 0 presents 3 words 0xA1, 0xA2, 0xA3 (last on 0xA3). Required: FIFO writes A1, A2, A3 on 3 consecutive edges starting 2 edges after valid; then IDLE; `words_written`=3.
- All 4 requesters always valid, `max_burst`=4, `req_last` never set. Required: grant order 0, 1, 2, 3, 0 in bursts of 4 words, one bubble between bursts; 20 words in 24 cycles.
- `full` forced high for 5 cycles mid-burst at word 2 of 4. Required: `wr_en`=0 and `req_ready`=0 for exactly those 5 cycles, no dropped or duplicated word, `burst_cnt` frozen, burst completes with 4 words.
- Owner drops `req_valid` after 1 word while req 2 is waiting. Required: grant releases after 1 word, and req 2 is granted on the next IDLE edge.
- `wr_rst` pulsed asynchronously during word 2 of a burst. Required: `wr_en`, `grant`, `busy` and `words_written` go to 0 immediately. After release, requester 0 is granted first.
- Preload `words_written` near wrap by running 65535 writes, then write 2 more. Required: counter reads 0xFFFF, 0x0000, 0x0001; FIFO contents correct end-to-end through the read side.
